bytecode_fetch: RTL and testbench
=================================

Name: bytecode_fetch

Overview:
- Request side of the byte-memory start/ready interface. Sequentially fetches bytecode bytes from a byte-wide memory responder starting at a program counter.
- Buffers the bytes in a small prefetch FIFO and presents them, each tagged with its address, to the bytecode decoder over a valid/ready interface.
- Supports a redirect (branch/jump) that flushes the buffer and discards any in-flight response.

Parameters:
ADDRESS_WIDTH, 8, width of memory address and PC
DEPTH, 4, prefetch FIFO entries (power of two, >=2)
PTR_WIDTH, 2, log2(DEPTH)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
mem_start  output  1  request strobe to responder, one cycle per request
mem_address  output  ADDRESS_WIDTH  request address, equals fetch_pc
mem_ready  input  1  responder idle; rising after a request means mem_data is valid
mem_data  input  8  response byte
redirect  input  1  load new fetch PC, flush buffer
redirect_pc  input  ADDRESS_WIDTH  new fetch PC
out_valid  output  1  head byte available
out_ready  input  1  decoder consumes head byte
out_data  output  8  head byte
out_pc  output  ADDRESS_WIDTH  address of head byte
fetch_pc  output  ADDRESS_WIDTH  next address to request

Behaviour:
- Reset (reset==0, async): FSM=IDLE, fetch_pc=0, FIFO empty, discard=0, out_valid=0, out_data=0, out_pc=0, mem_start=0.
- FSM states IDLE and WAIT.
- IDLE:
  - mem_start = mem_ready & ~redirect & (count < DEPTH), combinational. mem_address = fetch_pc.
  - On an issuing edge: fetch_pc <= fetch_pc+1 (wraps mod 2^ADDRESS_WIDTH); latch req_pc <= fetch_pc; go to WAIT.
- WAIT:
  - mem_start=0. Wait for mem_ready==1; the responder drops ready on the edge that accepts start, so ready in WAIT marks valid data.
  - On the edge with mem_ready==1: if discard==0, push {mem_data, req_pc}; clear discard; go to IDLE.
- Space rule: at most one request is outstanding. Issue only if FIFO count < DEPTH, so a push can never overflow.
- Latency: with a zero-delay responder, mem_start in cycle 0 puts the byte on out_* in cycle 3. Throughput is at most 1 byte per 3 cycles.
- Consumer: out_valid = FIFO non-empty; out_data/out_pc = head entry. Pop on out_valid & out_ready.
- Push and pop on the same edge are both honoured; count is unchanged.
- Redirect (sampled on clk edge), takes priority over everything:
  - FIFO flushed; same-cycle pop and push ignored.
  - fetch_pc <= redirect_pc.
  - If FSM==WAIT and mem_ready==0: discard <= 1 and stay in WAIT; that response is dropped when it arrives.
  - If FSM==WAIT and mem_ready==1: drop the response, go to IDLE.
  - No mem_start is issued in a redirect cycle.
- Redirect while discard is already 1: discard stays 1 and fetch_pc is updated again.
- out_valid=0 on the cycle after a redirect.
- Reset mid-request: state cleared immediately. The responder is reset by the same signal.
- fetch_pc wrap: 0xFF -> 0x00 for the default width, with no error.

Optional Feature:
- Macro BYTECODE_FETCH_PERF_EN.
- When defined:
  - Extra outputs perf_fetched[15:0] counts pushed bytes.
  - perf_stall[15:0] counts cycles with out_ready & ~out_valid.
  - perf_discard[7:0] counts dropped responses.
  - All counters saturate and reset to 0.
- When not defined: ports and logic are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package holds:
  - fetch FSM state enum (FETCH_IDLE, FETCH_WAIT)
  - reset PC constant (0)
  - byte width constant 8
- One sub-module, bytecode_fetch_fifo:
  - DEPTH x {8+ADDRESS_WIDTH} storage
  - push, pop, flush, count, empty, full
  - flush has priority over push and pop.

Test Plan:
- Responder with bytes 0x59,0x5C,0x57 at 0..2 and out_ready=1. After reset expect out sequence (0x00,0x59), (0x01,0x5C), (0x02,0x57); exactly one mem_start pulse per byte.
- out_ready=0 with DEPTH=4. FIFO fills with PCs 0..3; no mem_start issued while count==4. After one pop a request issues for PC 4.
- Delayed responder (address[1:0] cycles of delay). Redirect to 0x10 while in WAIT for PC 3: the PC 3 byte is never presented; the next out is (0x10, mem[0x10]).
- redirect asserted together with out_valid & out_ready. FIFO is empty next cycle; fetch_pc = redirect_pc; no pop side effect.
- redirect_pc=0xFE, then run 4 fetches. out_pc sequence is 0xFE, 0xFF, 0x00, 0x01.
- Assert reset while in WAIT. Next cycle out_valid=0, mem_start=0, fetch_pc=0. Fetching restarts at 0 and gives 0x59 first.

Source files
------------

// File: rtl/bytecode_fetch_pkg.sv
// +--------------------------------------------------------------------+
// | bytecode_fetch_pkg : shared types and constants for bytecode fetch |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package bytecode_fetch_pkg;

  typedef enum logic [0:0] {
    FETCH_IDLE = 1'b0,
    FETCH_WAIT = 1'b1
  } fetch_state_t;

  localparam int c_reset_pc   = 0;
  localparam int c_byte_width = 8;

endpackage

`default_nettype wire

// File: rtl/bytecode_fetch_fifo.sv
// +--------------------------------------------------------------------+
// | bytecode_fetch_fifo : prefetch buffer of {byte, address} entries   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module bytecode_fetch_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4,
  parameter int PTR_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic [PTR_WIDTH:0]    count,
  output logic                  empty,
  output logic                  full
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_WIDTH-1:0]  r_rd_ptr;
  logic [PTR_WIDTH-1:0]  r_wr_ptr;
  logic [PTR_WIDTH:0]    r_count;
  logic                  w_push;
  logic                  w_pop;

  assign empty    = (r_count == '0);
  assign full     = (r_count == (PTR_WIDTH+1)'(DEPTH));
  assign count    = r_count;
  assign pop_data = r_mem[r_rd_ptr];

  // A pop frees the slot a simultaneous push needs, so full only blocks a lone push.
  assign w_push = push & ~flush & (~full | pop);
  assign w_pop  = pop & ~flush & ~empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule

`default_nettype wire

// File: rtl/bytecode_fetch.sv
// +--------------------------------------------------------------------+
// | bytecode_fetch : sequential byte fetcher with prefetch and redirect|
// | Optional counters: define BYTECODE_FETCH_PERF_EN                   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module bytecode_fetch
  import bytecode_fetch_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DEPTH         = 4,
  parameter int PTR_WIDTH     = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     mem_start,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  input  logic                     mem_ready,
  input  logic [7:0]               mem_data,
  input  logic                     redirect,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [7:0]               out_data,
  output logic [ADDRESS_WIDTH-1:0] out_pc,
  output logic [ADDRESS_WIDTH-1:0] fetch_pc
`ifdef BYTECODE_FETCH_PERF_EN
  ,
  output logic [15:0]              perf_fetched,
  output logic [15:0]              perf_stall,
  output logic [7:0]               perf_discard
`endif
);

  localparam int c_entry_width = c_byte_width + ADDRESS_WIDTH;

  fetch_state_t             r_state;
  fetch_state_t             w_next_state;
  logic [ADDRESS_WIDTH-1:0] r_fetch_pc;
  logic [ADDRESS_WIDTH-1:0] r_req_pc;
  logic                     r_discard;
  logic                     w_issue;
  logic                     w_resp;
  logic                     w_push;
  logic                     w_pop;
  logic [c_entry_width-1:0] w_head;
  logic [PTR_WIDTH:0]       w_count;
  logic                     w_empty;
  logic                     w_full;

  assign w_issue = (r_state == FETCH_IDLE) & mem_ready & ~redirect &
                   (w_count < (PTR_WIDTH+1)'(DEPTH));
  assign w_resp  = (r_state == FETCH_WAIT) & mem_ready;
  assign w_push  = w_resp & ~r_discard & ~redirect & ~w_full;
  assign w_pop   = ~w_empty & out_ready & ~redirect;

  // The responder idles with ready high, so qualify the strobe while reset is held.
  assign mem_start   = reset & w_issue;
  assign mem_address = r_fetch_pc;
  assign fetch_pc    = r_fetch_pc;

  assign out_valid = ~w_empty;
  assign out_data  = w_empty ? '0 : w_head[c_entry_width-1 -: c_byte_width];
  assign out_pc    = w_empty ? '0 : w_head[ADDRESS_WIDTH-1:0];

  bytecode_fetch_fifo #(
    .DATA_WIDTH (c_entry_width),
    .DEPTH      (DEPTH),
    .PTR_WIDTH  (PTR_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (w_push),
    .push_data ({mem_data, r_req_pc}),
    .pop       (w_pop),
    .pop_data  (w_head),
    .count     (w_count),
    .empty     (w_empty),
    .full      (w_full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= FETCH_IDLE;
    else        r_state <= w_next_state;
  end

  // Redirect never changes the state: a pending WAIT must still absorb its response.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      FETCH_IDLE: if (w_issue)   w_next_state = FETCH_WAIT;
      FETCH_WAIT: if (mem_ready) w_next_state = FETCH_IDLE;
      default:                   w_next_state = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc <= ADDRESS_WIDTH'(c_reset_pc);
      r_req_pc   <= ADDRESS_WIDTH'(c_reset_pc);
      r_discard  <= 1'b0;
    end else begin
      if (redirect)     r_fetch_pc <= redirect_pc;
      else if (w_issue) r_fetch_pc <= r_fetch_pc + 1'b1;
      if (w_issue) r_req_pc <= r_fetch_pc;
      if (r_state == FETCH_WAIT) begin
        if (mem_ready)     r_discard <= 1'b0;
        else if (redirect) r_discard <= 1'b1;
      end
    end
  end

`ifdef BYTECODE_FETCH_PERF_EN
  logic [15:0] r_perf_fetched;
  logic [15:0] r_perf_stall;
  logic [7:0]  r_perf_discard;
  logic        w_drop;

  assign w_drop       = w_resp & (r_discard | redirect);
  assign perf_fetched = r_perf_fetched;
  assign perf_stall   = r_perf_stall;
  assign perf_discard = r_perf_discard;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_perf_fetched <= '0;
      r_perf_stall   <= '0;
      r_perf_discard <= '0;
    end else begin
      if (w_push && r_perf_fetched != '1)              r_perf_fetched <= r_perf_fetched + 1'b1;
      if (out_ready && w_empty && r_perf_stall != '1)  r_perf_stall   <= r_perf_stall + 1'b1;
      if (w_drop && r_perf_discard != '1)              r_perf_discard <= r_perf_discard + 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_bytecode_fetch.sv
// Scoreboard bench for bytecode_fetch: directed fetch, backpressure, redirect,
// wrap and reset scenarios against a behavioural byte-memory responder.
`default_nettype none

module tb_bytecode_fetch;

  logic       clk = 1'b0;
  logic       reset;
  logic       mem_start;
  logic [7:0] mem_address;
  logic       mem_ready;
  logic [7:0] mem_data;
  logic       redirect;
  logic [7:0] redirect_pc;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [7:0] out_pc;
  logic [7:0] fetch_pc;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] data;
    logic [7:0] pc;
  } exp_t;
  exp_t exp_q[$];
  logic [7:0] exp_addr;

  logic [7:0] mem [256];
  logic       delay_en;
  logic [7:0] resp_addr;
  logic [1:0] resp_cnt;

  always #5 clk = ~clk;

  bytecode_fetch #(
    .ADDRESS_WIDTH (8),
    .DEPTH         (4),
    .PTR_WIDTH     (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_start   (mem_start),
    .mem_address (mem_address),
    .mem_ready   (mem_ready),
    .mem_data    (mem_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_pc      (out_pc),
    .fetch_pc    (fetch_pc)
  );

  // Responder: drops ready on the accepting edge, raises it with data after
  // 0 cycles (or address[1:0] cycles when delay_en) of extra latency.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_ready <= 1'b1;
      mem_data  <= 8'h00;
      resp_addr <= 8'h00;
      resp_cnt  <= 2'd0;
    end else if (mem_start) begin
      mem_ready <= 1'b0;
      resp_addr <= mem_address;
      resp_cnt  <= delay_en ? mem_address[1:0] : 2'd0;
    end else if (!mem_ready) begin
      if (resp_cnt == 2'd0) begin
        mem_ready <= 1'b1;
        mem_data  <= mem[resp_addr];
      end else begin
        resp_cnt <= resp_cnt - 2'd1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: output handshakes against the scoreboard, request addresses against exp_addr.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready && !redirect) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_out actual=(%0h,%0h) required=none", out_pc, out_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (out_data !== e.data || out_pc !== e.pc) begin
          errors++;
          $display("FAIL out_entry actual=(%0h,%0h) required=(%0h,%0h)",
                   out_pc, out_data, e.pc, e.data);
        end
      end
    end
    if (mem_start) begin
      checks++;
      if (mem_address !== exp_addr) begin
        errors++;
        $display("FAIL mem_address actual=%0h required=%0h", mem_address, exp_addr);
      end
      exp_addr = exp_addr + 8'd1;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input logic [7:0] pc, input logic [7:0] data);
    exp_t e;
    e.pc   = pc;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic do_reset;
    reset = 1'b0;
    exp_q.delete();
    exp_addr = 8'h00;
    tick;
    tick;
    reset = 1'b1;
  endtask

  task automatic do_redirect(input logic [7:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    exp_q.delete();
    exp_addr = pc;
    tick;
    redirect = 1'b0;
  endtask

  // Hold out_ready high until exactly n bytes have been consumed.
  task automatic drain(input int n, input int budget);
    int got = 0;
    int cyc = 0;
    out_ready = 1'b1;
    while (got < n && cyc < budget) begin
      @(negedge clk);
      if (out_valid && !redirect) got++;
      @(posedge clk);
      #1;
      cyc++;
    end
    out_ready = 1'b0;
    check("drain_count", got, n);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 3 + 8'h21);
    mem[0] = 8'h59;
    mem[1] = 8'h5C;
    mem[2] = 8'h57;
    reset       = 1'b0;
    out_ready   = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 8'h00;
    delay_en    = 1'b0;
    exp_addr    = 8'h00;
    tick;
    tick;

    check("rst_out_valid", out_valid, 0);
    check("rst_mem_start", mem_start, 0);
    check("rst_fetch_pc", fetch_pc, 8'h00);
    check("rst_out_data", out_data, 8'h00);
    check("rst_out_pc", out_pc, 8'h00);

    // Basic streaming
    reset = 1'b1;
    expect_out(8'h00, 8'h59);
    expect_out(8'h01, 8'h5C);
    expect_out(8'h02, 8'h57);
    drain(3, 30);
    check("t1_drained", exp_q.size(), 0);

    // Backpressure: buffer fills with PCs 0..3 then requests stop
    do_reset;
    repeat (20) tick;
    check("t2_fetch_pc", fetch_pc, 8'h04);
    check("t2_no_start", mem_start, 0);
    check("t2_out_valid", out_valid, 1);
    check("t2_head_pc", out_pc, 8'h00);
    check("t2_head_data", out_data, 8'h59);
    repeat (3) tick;
    check("t2_still_no_start", mem_start, 0);
    expect_out(8'h00, 8'h59);
    expect_out(8'h01, 8'h5C);
    expect_out(8'h02, 8'h57);
    expect_out(8'h03, 8'h2A);
    expect_out(8'h04, 8'h2D);
    drain(1, 5);
    check("t2_start_after_pop", mem_start, 1);
    check("t2_start_addr", mem_address, 8'h04);
    drain(4, 20);

    // Redirect while waiting on a slow response for PC 3
    delay_en = 1'b1;
    do_reset;
    expect_out(8'h00, 8'h59);
    expect_out(8'h01, 8'h5C);
    expect_out(8'h02, 8'h57);
    drain(3, 40);
    for (int k = 0; k < 20 && fetch_pc != 8'h04; k++) tick;
    check("t3_wait_pc3", fetch_pc, 8'h04);
    do_redirect(8'h10);
    check("t3_flushed", out_valid, 0);
    check("t3_fetch_pc", fetch_pc, 8'h10);
    expect_out(8'h10, 8'h51);
    drain(1, 40);
    delay_en = 1'b0;

    // Redirect coincident with a consumer handshake
    do_reset;
    for (int k = 0; k < 20 && !out_valid; k++) tick;
    check("t4_have_byte", out_valid, 1);
    out_ready = 1'b1;
    do_redirect(8'h40);
    out_ready = 1'b0;
    check("t4_flushed", out_valid, 0);
    check("t4_fetch_pc", fetch_pc, 8'h40);
    expect_out(8'h40, 8'hE1);
    drain(1, 20);

    // fetch_pc wrap-around
    do_redirect(8'hFE);
    expect_out(8'hFE, 8'h1B);
    expect_out(8'hFF, 8'h1E);
    expect_out(8'h00, 8'h59);
    expect_out(8'h01, 8'h5C);
    drain(4, 40);

    // Reset while a request is outstanding
    for (int k = 0; k < 20 && !mem_start; k++) tick;
    check("t6_saw_start", mem_start, 1);
    tick;
    reset = 1'b0;
    exp_q.delete();
    exp_addr = 8'h00;
    #1;
    check("t6_out_valid", out_valid, 0);
    check("t6_mem_start", mem_start, 0);
    check("t6_fetch_pc", fetch_pc, 8'h00);
    tick;
    reset = 1'b1;
    expect_out(8'h00, 8'h59);
    drain(1, 20);

    repeat (3) tick;
    check("final_scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
